// File: rtl/display_pkg.sv
// Shared types and geometry constants for the display fetch path.
package display_pkg;

    localparam int PIX_W_DEF      = 24;
    localparam int SRC_W_DEF      = 80;
    localparam int SRC_H_DEF      = 60;
    localparam int SCALE_LOG2_DEF = 3;

    typedef logic [PIX_W_DEF-1:0] pixel_t;

    // Output raster dimension for a source dimension and upscale exponent.
    function automatic int out_dim(input int src, input int scale_log2);
        return src << scale_log2;
    endfunction

    localparam int OUT_W_DEF = SRC_W_DEF << SCALE_LOG2_DEF;
    localparam int OUT_H_DEF = SRC_H_DEF << SCALE_LOG2_DEF;

endpackage

// File: rtl/pixel_skid_buf.sv
// Two-entry show-ahead buffer; dout is the head entry whenever occ != 0.
module pixel_skid_buf
#(
    parameter int W = 26
)
(
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic [1:0]   occ
);

    logic [W-1:0] e0, e1;

    assign dout = e0;

    // FIFO-ordered storage; push while full is prevented upstream.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            e0  <= '0;
            e1  <= '0;
            occ <= 2'd0;
        end else begin
            case (occ)
                2'd0: begin
                    if (push) begin
                        e0  <= din;
                        occ <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        e0 <= din;
                    end else if (push) begin
                        e1  <= din;
                        occ <= 2'd2;
                    end else if (pop) begin
                        occ <= 2'd0;
                    end
                end
                default: begin
                    if (pop) begin
                        e0 <= e1;
                        if (push) begin
                            e1  <= din;
                            occ <= 2'd2;
                        end else begin
                            occ <= 2'd1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/display_fetch.sv
// Pixel fetch engine: walks the source frame with integer upscaling and
// streams pixels to the display FIFO through a 2-entry skid buffer.
module display_fetch
    import display_pkg::*;
#(
    parameter int PIX_W      = PIX_W_DEF,
    parameter int ADDR_W     = 13,
    parameter int SRC_W      = SRC_W_DEF,
    parameter int SRC_H      = SRC_H_DEF,
    parameter int SCALE_LOG2 = SCALE_LOG2_DEF
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              fifo_full,
    input  logic [PIX_W-1:0]  pixel_in,
    output logic [ADDR_W-1:0] addr,
    output logic [PIX_W-1:0]  pixel_out,
    output logic              fifo_write,
    output logic              sof,
    output logic              frame_done
);

    localparam int OUT_W = out_dim(SRC_W, SCALE_LOG2);
    localparam int OUT_H = out_dim(SRC_H, SCALE_LOG2);
    localparam int XW    = $clog2(OUT_W + 1);
    localparam int YW    = $clog2(OUT_H + 1);
    localparam int EW    = PIX_W + 2;

    localparam logic [XW-1:0]     X_LAST    = XW'(OUT_W - 1);
    localparam logic [YW-1:0]     Y_LAST    = YW'(OUT_H - 1);
    localparam logic [YW-1:0]     REP_MASK  = YW'((1 << SCALE_LOG2) - 1);
    localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(SRC_W);

    logic [XW-1:0]     ox;
    logic [YW-1:0]     oy;
    logic [ADDR_W-1:0] line_base;
    logic              pending, pend_sof, pend_last;
    logic [1:0]        occ;
    logic [EW-1:0]     head;
    logic [2:0]        fill;
    logic              pop, issue;
    logic              at_x_last, at_y_last, line_rep_done;

    // Head entry layout: {sof tag, last tag, pixel}.
    pixel_skid_buf #(.W(EW)) u_skid (
        .clk  (clk),
        .rst  (rst),
        .push (pending),
        .pop  (pop),
        .din  ({pend_sof, pend_last, pixel_in}),
        .dout (head),
        .occ  (occ)
    );

    assign pop        = (occ != 2'd0) && !fifo_full;
    assign fifo_write = pop;
    assign pixel_out  = head[PIX_W-1:0];
    assign sof        = pop && head[PIX_W+1];

    // Pixels already owed to the buffer after this edge must leave room.
    assign fill  = {1'b0, occ} + {2'b00, pending} - {2'b00, pop};
    assign issue = en && (fill < 3'd2);

    assign at_x_last     = (ox == X_LAST);
    assign at_y_last     = (oy == Y_LAST);
    // Last replica of a source line: next output line uses the next source line.
    assign line_rep_done = ((oy & REP_MASK) == REP_MASK);

    // Read issue, raster position walk and frame_done pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr       <= '0;
            ox         <= '0;
            oy         <= '0;
            line_base  <= '0;
            pending    <= 1'b0;
            pend_sof   <= 1'b0;
            pend_last  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            pending    <= issue;
            frame_done <= pop && head[PIX_W];
            if (issue) begin
                addr      <= line_base + ADDR_W'(ox >> SCALE_LOG2);
                pend_sof  <= (ox == '0) && (oy == '0);
                pend_last <= at_x_last && at_y_last;
                if (at_x_last) begin
                    ox <= '0;
                    if (at_y_last) begin
                        oy        <= '0;
                        line_base <= '0;
                    end else begin
                        oy <= oy + YW'(1);
                        if (line_rep_done)
                            line_base <= line_base + LINE_STEP;
                    end
                end else begin
                    ox <= ox + XW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_display_fetch.sv
// Directed bench for display_fetch on a reduced 10x6 source frame, x8 upscale.
module tb_display_fetch;

    localparam int SW    = 10;
    localparam int SH    = 6;
    localparam int S     = 3;
    localparam int OW    = SW << S;
    localparam int OH    = SH << S;
    localparam int FRAME = OW * OH;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic        fifo_full = 1'b0;
    logic [23:0] pixel_in;
    logic [12:0] addr;
    logic [23:0] pixel_out;
    logic        fifo_write, sof, frame_done;

    int total = 0;
    int bad   = 0;
    int wr_idx = 0;

    logic        w, s, fd;
    logic [23:0] d;
    logic [12:0] a;

    display_fetch #(
        .PIX_W(24), .ADDR_W(13), .SRC_W(SW), .SRC_H(SH), .SCALE_LOG2(S)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .fifo_full(fifo_full),
        .pixel_in(pixel_in), .addr(addr), .pixel_out(pixel_out),
        .fifo_write(fifo_write), .sof(sof), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Pattern memory: data equals address, available while addr is held.
    assign pixel_in = 24'(addr);

    // Reference raster: value of the k-th written pixel.
    function automatic int exp_pix(input int k);
        int idx;
        idx = k % FRAME;
        return ((idx / OW) >> S) * SW + ((idx % OW) >> S);
    endfunction

    // Sample DUT outputs at the falling edge.
    task automatic tick();
        @(negedge clk);
        w  = fifo_write;
        s  = sof;
        fd = frame_done;
        d  = pixel_out;
        a  = addr;
    endtask

    task automatic test_reset();
        rst = 1'b0; en = 1'b1; fifo_full = 1'b0;
        repeat (3) tick();
        total++; if (w !== 1'b0)  begin bad++; $display("FAIL reset_write got=%b exp=0", w); end
        total++; if (a !== 13'd0) begin bad++; $display("FAIL reset_addr got=%0d exp=0", a); end
        total++; if (d !== 24'd0) begin bad++; $display("FAIL reset_pixel got=%0d exp=0", d); end
        total++; if (s !== 1'b0)  begin bad++; $display("FAIL reset_sof got=%b exp=0", s); end
        total++; if (fd !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", fd); end
    endtask

    task automatic test_stream();
        logic [23:0] d7, d8, d639, d640;
        d7 = '0; d8 = '0; d639 = '0; d640 = '0;
        rst = 1'b1;
        wr_idx = 0;
        tick();
        total++; if (w !== 1'b0) begin bad++; $display("FAIL latency_c1 got=%b exp=0", w); end
        tick();
        total++; if (w !== 1'b1) begin bad++; $display("FAIL latency_c2 got=%b exp=1", w); end
        total++; if (d !== 24'd0) begin bad++; $display("FAIL first_pix got=%0d exp=0", d); end
        total++; if (s !== 1'b1) begin bad++; $display("FAIL first_sof got=%b exp=1", s); end
        if (w) wr_idx++;
        for (int k = 0; k < 819; k++) begin
            tick();
            total++;
            if (w !== 1'b1) begin
                bad++; $display("FAIL stream_rate idx=%0d got=%b exp=1", wr_idx, w);
            end else begin
                total++;
                if (d !== 24'(exp_pix(wr_idx))) begin
                    bad++; $display("FAIL stream_pix idx=%0d got=%0d exp=%0d", wr_idx, d, exp_pix(wr_idx));
                end
                if (wr_idx == 7)   d7 = d;
                if (wr_idx == 8)   d8 = d;
                if (wr_idx == 639) d639 = d;
                if (wr_idx == 640) d640 = d;
                wr_idx++;
            end
        end
        total++; if (d7 !== 24'd0)   begin bad++; $display("FAIL rep_x7 got=%0d exp=0", d7); end
        total++; if (d8 !== 24'd1)   begin bad++; $display("FAIL rep_x8 got=%0d exp=1", d8); end
        total++; if (d639 !== 24'd9) begin bad++; $display("FAIL line7_end got=%0d exp=9", d639); end
        total++; if (d640 !== 24'd10) begin bad++; $display("FAIL line8_start got=%0d exp=10", d640); end
    endtask

    task automatic test_stall();
        fifo_full = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            total++; if (w !== 1'b0) begin bad++; $display("FAIL stall_write cyc=%0d got=%b exp=0", k, w); end
        end
        total++;
        if (a !== 13'(exp_pix(wr_idx + 1))) begin
            bad++; $display("FAIL stall_addr got=%0d exp=%0d", a, exp_pix(wr_idx + 1));
        end
        fifo_full = 1'b0;
        for (int k = 0; k < 30; k++) begin
            tick();
            total++;
            if (w !== 1'b1) begin
                bad++; $display("FAIL unstall_rate cyc=%0d got=%b exp=1", k, w);
            end else begin
                total++;
                if (d !== 24'(exp_pix(wr_idx))) begin
                    bad++; $display("FAIL unstall_pix idx=%0d got=%0d exp=%0d", wr_idx, d, exp_pix(wr_idx));
                end
                wr_idx++;
            end
        end
    endtask

    task automatic test_toggle();
        int nw;
        nw = 0;
        for (int k = 0; k < 100; k++) begin
            fifo_full = (k % 2 == 0);
            tick();
            total++;
            if (w !== ~fifo_full) begin
                bad++; $display("FAIL toggle_write cyc=%0d got=%b exp=%b", k, w, ~fifo_full);
            end
            if (w === 1'b1) begin
                total++;
                if (d !== 24'(exp_pix(wr_idx))) begin
                    bad++; $display("FAIL toggle_pix idx=%0d got=%0d exp=%0d", wr_idx, d, exp_pix(wr_idx));
                end
                wr_idx++;
                nw++;
            end
        end
        fifo_full = 1'b0;
        total++; if (nw != 50) begin bad++; $display("FAIL toggle_count got=%0d exp=50", nw); end
    endtask

    task automatic test_frame();
        logic        prev_last, wrap_seen;
        logic [12:0] prev_a;
        int          n_done, n_sof, cyc;
        prev_last = 1'b0; wrap_seen = 1'b0; prev_a = '0;
        n_done = 0; n_sof = 0; cyc = 0;
        while (wr_idx < FRAME + 4 && cyc < 6000) begin
            tick();
            cyc++;
            total++;
            if (fd !== prev_last) begin
                bad++; $display("FAIL frame_done idx=%0d got=%b exp=%b", wr_idx, fd, prev_last);
            end
            if (fd === 1'b1) n_done++;
            if (prev_a == 13'(SW * SH - 1) && a == 13'd0) wrap_seen = 1'b1;
            prev_a = a;
            prev_last = 1'b0;
            total++;
            if (w !== 1'b1) begin
                bad++; $display("FAIL frame_rate idx=%0d got=%b exp=1", wr_idx, w);
            end else begin
                total++;
                if (d !== 24'(exp_pix(wr_idx))) begin
                    bad++; $display("FAIL frame_pix idx=%0d got=%0d exp=%0d", wr_idx, d, exp_pix(wr_idx));
                end
                total++;
                if (s !== (wr_idx % FRAME == 0)) begin
                    bad++; $display("FAIL frame_sof idx=%0d got=%b exp=%b", wr_idx, s, wr_idx % FRAME == 0);
                end
                if (s === 1'b1) n_sof++;
                prev_last = (wr_idx % FRAME == FRAME - 1);
                wr_idx++;
            end
        end
        total++; if (wr_idx < FRAME + 4) begin bad++; $display("FAIL frame_timeout got=%0d exp>=%0d", wr_idx, FRAME + 4); end
        total++; if (!wrap_seen) begin bad++; $display("FAIL addr_wrap got=0 exp=1"); end
        total++; if (n_done != 1) begin bad++; $display("FAIL done_count got=%0d exp=1", n_done); end
        total++; if (n_sof != 1) begin bad++; $display("FAIL sof_count got=%0d exp=1", n_sof); end
    endtask

    task automatic test_enable();
        int extra;
        logic got;
        extra = 0;
        en = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (w === 1'b1) begin
                total++;
                if (d !== 24'(exp_pix(wr_idx))) begin
                    bad++; $display("FAIL drain_pix idx=%0d got=%0d exp=%0d", wr_idx, d, exp_pix(wr_idx));
                end
                wr_idx++;
                extra++;
            end
        end
        total++; if (extra > 2) begin bad++; $display("FAIL drain_count got=%0d exp<=2", extra); end
        total++; if (w !== 1'b0) begin bad++; $display("FAIL drain_idle got=%b exp=0", w); end
        en = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 6 && !got; k++) begin
            tick();
            if (w === 1'b1) got = 1'b1;
        end
        total++; if (!got) begin bad++; $display("FAIL resume_timeout got=0 exp=1"); end
        if (got) begin
            total++;
            if (d !== 24'(exp_pix(wr_idx))) begin
                bad++; $display("FAIL resume_pix idx=%0d got=%0d exp=%0d", wr_idx, d, exp_pix(wr_idx));
            end
            wr_idx++;
        end
        for (int k = 0; k < 12; k++) begin
            tick();
            total++;
            if (w !== 1'b1 || d !== 24'(exp_pix(wr_idx))) begin
                bad++; $display("FAIL resume_seq idx=%0d got=%b/%0d exp=1/%0d", wr_idx, w, d, exp_pix(wr_idx));
            end
            if (w === 1'b1) wr_idx++;
        end
    endtask

    task automatic test_async_reset();
        @(posedge clk);
        #2;
        total++; if (fifo_write !== 1'b1) begin bad++; $display("FAIL pre_reset_write got=%b exp=1", fifo_write); end
        rst = 1'b0;
        #1;
        total++; if (fifo_write !== 1'b0) begin bad++; $display("FAIL async_write got=%b exp=0", fifo_write); end
        total++; if (addr !== 13'd0) begin bad++; $display("FAIL async_addr got=%0d exp=0", addr); end
        tick();
        total++; if (w !== 1'b0) begin bad++; $display("FAIL held_reset_write got=%b exp=0", w); end
        rst = 1'b1;
        wr_idx = 0;
        tick();
        total++; if (w !== 1'b0) begin bad++; $display("FAIL rst2_c1 got=%b exp=0", w); end
        tick();
        total++; if (w !== 1'b1 || d !== 24'd0) begin bad++; $display("FAIL rst2_first got=%b/%0d exp=1/0", w, d); end
        total++; if (s !== 1'b1) begin bad++; $display("FAIL rst2_sof got=%b exp=1", s); end
        if (w === 1'b1) wr_idx++;
        for (int k = 0; k < 10; k++) begin
            tick();
            total++;
            if (w !== 1'b1 || d !== 24'(exp_pix(wr_idx))) begin
                bad++; $display("FAIL rst2_seq idx=%0d got=%b/%0d exp=1/%0d", wr_idx, w, d, exp_pix(wr_idx));
            end
            if (w === 1'b1) wr_idx++;
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_toggle();
        test_frame();
        test_enable();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
